// File: rtl/wallace_dot_acc.sv
// Dot-product accumulator placed directly after the 8x8 Wallace multiplier.
// It accepts VEC_LEN unsigned products over a valid/ready handshake, sums them
// modulo 2^ACC_W, and holds the result on a second valid/ready interface.
// A sticky overflow flag records any wrap past 2^ACC_W, and clr discards a
// partial vector.
module wallace_dot_acc #(
   parameter int unsigned PROD_W  = 17,
   parameter int unsigned VEC_LEN = 8,
   parameter int unsigned ACC_W   = 20,
   parameter int unsigned CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PROD_W-1:0] prod_in,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic              clr,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic              acc_ovf,
   output logic [CNT_W-1:0]  count_out
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

   state_t             state_q, state_n;
   logic [ACC_W-1:0]   sum_q, sum_n;
   logic               run_ovf_q, run_ovf_n;
   logic [CNT_W-1:0]   count_q, count_n;
   logic [ACC_W-1:0]   acc_out_q, acc_out_n;
   logic               acc_ovf_q, acc_ovf_n;

   logic [ACC_W-1:0]   prod_ext;
   logic [ACC_W:0]     add_full;
   logic               carry;

   // Products wider than the accumulator are truncated to its low bits without
   // flagging; narrower products are zero-extended.
   if (PROD_W >= ACC_W) begin : g_trunc
      assign prod_ext = prod_in[ACC_W-1:0];
   end else begin : g_zext
      assign prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod_in};
   end

   assign add_full = {1'b0, sum_q} + {1'b0, prod_ext};
   assign carry    = add_full[ACC_W];

   assign acc_valid  = (state_q == HOLD);
   assign prod_ready = ~acc_valid;
   assign acc_out    = acc_out_q;
   assign acc_ovf    = acc_ovf_q;
   assign count_out  = count_q;

   // Next-state logic: clr beats accept in ACCUM; HOLD waits only for acc_ready.
   always_comb begin
      state_n   = state_q;
      sum_n     = sum_q;
      run_ovf_n = run_ovf_q;
      count_n   = count_q;
      acc_out_n = acc_out_q;
      acc_ovf_n = acc_ovf_q;
      case (state_q)
         ACCUM: begin
            if (clr) begin
               sum_n     = '0;
               run_ovf_n = 1'b0;
               count_n   = '0;
            end else if (prod_valid) begin
               if (count_q == LAST_CNT) begin
                  acc_out_n = add_full[ACC_W-1:0];
                  acc_ovf_n = run_ovf_q | carry;
                  sum_n     = '0;
                  run_ovf_n = 1'b0;
                  count_n   = '0;
                  state_n   = HOLD;
               end else begin
                  sum_n     = add_full[ACC_W-1:0];
                  run_ovf_n = run_ovf_q | carry;
                  count_n   = count_q + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (acc_ready) begin
               state_n = ACCUM;
            end
         end
         default: state_n = ACCUM;
      endcase
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ACCUM;
         sum_q     <= '0;
         run_ovf_q <= 1'b0;
         count_q   <= '0;
         acc_out_q <= '0;
         acc_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_n;
         sum_q     <= sum_n;
         run_ovf_q <= run_ovf_n;
         count_q   <= count_n;
         acc_out_q <= acc_out_n;
         acc_ovf_q <= acc_ovf_n;
      end
   end

endmodule

// File: tb/tb_wallace_dot_acc.sv
// Self-checking bench for wallace_dot_acc. Two instances share all inputs:
// the default 20-bit accumulator and an 18-bit one that wraps on large vectors.
// Expected vector totals are queued as stimulus is planned and checked when
// the output handshake occurs.
module tb_wallace_dot_acc;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] prod_in;
   logic        prod_valid;
   logic        clr;
   logic        acc_ready;

   logic        prod_ready,   prod_ready18;
   logic [19:0] acc_out;
   logic [17:0] acc_out18;
   logic        acc_valid,    acc_valid18;
   logic        acc_ovf,      acc_ovf18;
   logic [7:0]  count_out,    count_out18;

   int total = 0;
   int bad   = 0;
   int unsigned exp_q[$];

   always #5 clk = ~clk;

   wallace_dot_acc #(.PROD_W(17), .VEC_LEN(8), .ACC_W(20), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
      .prod_ready(prod_ready), .clr(clr), .acc_out(acc_out),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_ovf(acc_ovf),
      .count_out(count_out)
   );

   wallace_dot_acc #(.PROD_W(17), .VEC_LEN(8), .ACC_W(18), .CNT_W(8)) u_dut18 (
      .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
      .prod_ready(prod_ready18), .clr(clr), .acc_out(acc_out18),
      .acc_valid(acc_valid18), .acc_ready(acc_ready), .acc_ovf(acc_ovf18),
      .count_out(count_out18)
   );

   // Scoreboard: every output handshake pops one planned vector total.
   always @(negedge clk) begin
      if (rst === 1'b0 && acc_valid === 1'b1 && acc_ready === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got result %0d, required none", acc_out);
         end else begin
            int unsigned t;
            t = exp_q.pop_front();
            if (acc_out !== 20'(t % (1 << 20)) || acc_ovf !== (t >= (1 << 20))) begin
               bad++;
               $display("FAIL sb_w20: got %0d/%0b required %0d/%0b",
                        acc_out, acc_ovf, t % (1 << 20), t >= (1 << 20));
            end
            total++;
            if (acc_valid18 !== 1'b1 || acc_out18 !== 18'(t % (1 << 18)) ||
                acc_ovf18 !== (t >= (1 << 18))) begin
               bad++;
               $display("FAIL sb_w18: got %0d/%0b/v%0b required %0d/%0b/v1",
                        acc_out18, acc_ovf18, acc_valid18, t % (1 << 18), t >= (1 << 18));
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Present v and hold it until a rising edge where prod_ready was high.
   task automatic send(input logic [16:0] v);
      int unsigned n;
      logic r;
      prod_valid = 1'b1;
      prod_in    = v;
      n = 0;
      do begin
         r = prod_ready;
         tick();
         n++;
      end while (!r && n < 50);
      total++;
      if (!r) begin
         bad++;
         $display("FAIL send_timeout: prod_ready=%0b required 1", r);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; prod_valid = 1'b0; prod_in = '0; clr = 1'b0; acc_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      total += 5;
      if (acc_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b required 0", acc_valid); end
      if (prod_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b required 1", prod_ready); end
      if (count_out !== 8'd0) begin bad++; $display("FAIL rst_count: got %0d required 0", count_out); end
      if (acc_out !== 20'd0) begin bad++; $display("FAIL rst_acc: got %0d required 0", acc_out); end
      if (prod_ready18 !== 1'b1) begin bad++; $display("FAIL rst_ready18: got %0b required 1", prod_ready18); end
   endtask

   task automatic test_back_to_back;
      acc_ready = 1'b1;
      exp_q.push_back(36);
      for (int i = 1; i <= 8; i++) begin
         send(17'(i));
         total++;
         if (count_out !== 8'(i % 8)) begin
            bad++; $display("FAIL b2b_count%0d: got %0d required %0d", i, count_out, i % 8);
         end
      end
      prod_valid = 1'b0;
      total += 4;
      if (acc_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %0b required 1", acc_valid); end
      if (prod_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready: got %0b required 0", prod_ready); end
      if (acc_out !== 20'd36) begin bad++; $display("FAIL b2b_acc: got %0d required 36", acc_out); end
      if (acc_ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf: got %0b required 0", acc_ovf); end
      tick();
      total++;
      if (acc_valid !== 1'b0) begin bad++; $display("FAIL b2b_one_cycle: got %0b required 0", acc_valid); end
   endtask

   task automatic test_overflow;
      acc_ready = 1'b1;
      exp_q.push_back(8 * 65025);
      for (int i = 0; i < 8; i++) send(17'd65025);
      prod_valid = 1'b0;
      total += 4;
      if (acc_out !== 20'd520200) begin bad++; $display("FAIL ovf_acc20: got %0d required 520200", acc_out); end
      if (acc_ovf !== 1'b0) begin bad++; $display("FAIL ovf_flag20: got %0b required 0", acc_ovf); end
      if (acc_out18 !== 18'd258056) begin bad++; $display("FAIL ovf_acc18: got %0d required 258056", acc_out18); end
      if (acc_ovf18 !== 1'b1) begin bad++; $display("FAIL ovf_flag18: got %0b required 1", acc_ovf18); end
      tick();
      exp_q.push_back(8);
      for (int i = 0; i < 8; i++) send(17'd1);
      prod_valid = 1'b0;
      total += 2;
      if (acc_out18 !== 18'd8) begin bad++; $display("FAIL ovf_next_acc18: got %0d required 8", acc_out18); end
      if (acc_ovf18 !== 1'b0) begin bad++; $display("FAIL ovf_next_flag18: got %0b required 0", acc_ovf18); end
      tick();
   endtask

   task automatic test_hold;
      acc_ready = 1'b0;
      exp_q.push_back(24);
      for (int i = 0; i < 8; i++) send(17'd3);
      prod_valid = 1'b1;
      prod_in    = 17'd7;
      for (int i = 0; i < 5; i++) begin
         total += 3;
         if (acc_out !== 20'd24) begin bad++; $display("FAIL hold_acc%0d: got %0d required 24", i, acc_out); end
         if (prod_ready !== 1'b0) begin bad++; $display("FAIL hold_ready%0d: got %0b required 0", i, prod_ready); end
         if (count_out !== 8'd0) begin bad++; $display("FAIL hold_count%0d: got %0d required 0", i, count_out); end
         tick();
      end
      acc_ready = 1'b1;
      exp_q.push_back(14);
      tick();
      total += 2;
      if (acc_valid !== 1'b0) begin bad++; $display("FAIL hold_release: got %0b required 0", acc_valid); end
      if (count_out !== 8'd0) begin bad++; $display("FAIL hold_bubble: got %0d required 0", count_out); end
      tick();
      total++;
      if (count_out !== 8'd1) begin bad++; $display("FAIL hold_first: got %0d required 1", count_out); end
      for (int i = 0; i < 7; i++) send(17'd1);
      prod_valid = 1'b0;
      tick();
   endtask

   task automatic test_clr;
      acc_ready = 1'b1;
      send(17'd10); send(17'd20); send(17'd30);
      total++;
      if (count_out !== 8'd3) begin bad++; $display("FAIL clr_pre: got %0d required 3", count_out); end
      clr = 1'b1; prod_valid = 1'b1; prod_in = 17'd99;
      total++;
      if (prod_ready !== 1'b1) begin bad++; $display("FAIL clr_ready: got %0b required 1", prod_ready); end
      tick();
      clr = 1'b0; prod_valid = 1'b0;
      total++;
      if (count_out !== 8'd0) begin bad++; $display("FAIL clr_count: got %0d required 0", count_out); end
      exp_q.push_back(16);
      for (int i = 0; i < 8; i++) send(17'd2);
      prod_valid = 1'b0;
      total++;
      if (acc_out !== 20'd16) begin bad++; $display("FAIL clr_acc: got %0d required 16", acc_out); end
      tick();
   endtask

   task automatic test_rst_mid;
      acc_ready = 1'b1;
      for (int i = 0; i < 5; i++) send(17'd100);
      prod_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total += 2;
      if (count_out !== 8'd0) begin bad++; $display("FAIL rstmid_count: got %0d required 0", count_out); end
      if (acc_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %0b required 0", acc_valid); end
      exp_q.push_back(36);
      for (int i = 1; i <= 8; i++) begin
         int unsigned gap;
         gap = $urandom_range(0, 2);
         prod_valid = 1'b0;
         for (int g = 0; g < int'(gap); g++) tick();
         send(17'(i));
      end
      prod_valid = 1'b0;
      total++;
      if (acc_out !== 20'd36) begin bad++; $display("FAIL rstmid_acc: got %0d required 36", acc_out); end
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_overflow();
      test_hold();
      test_clr();
      test_rst_mid();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL sb_drain: got %0d results outstanding, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
